lsu_mem: RTL and testbench

- Parametrised data-memory load/store unit for the npc core; successor to the single-cycle data memory.
- Adds a valid/ready request/response handshake, a configurable memory latency, byte-lane extraction by address offset, and misaligned/illegal-op error reporting.
- Sits between the core's execute/memory stage and the DPI-C physical memory model: pmem_read(raddr) returns 32 bits; pmem_write(waddr, wdata, len).
- Used by the multicycle core; one transaction in flight at a time.

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/lsu_mem_if.sv | 25 ++
 rtl/lsu_extract.sv | 29 ++
 rtl/lsu_mem.sv | 140 ++++++++++++++
 tb/tb_lsu_mem.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the lsu_mem load/store unit: access-op codes,
// FSM state encoding and small op-decoding helpers.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Byte count handed to the memory write port; 0 marks an illegal op.
  function automatic logic [3:0] store_len(input logic [2:0] ctr);
    case (ctr)
      LB, LBU: store_len = 4'd1;
      LH, LHU: store_len = 4'd2;
      LW:      store_len = 4'd4;
      default: store_len = 4'd0;
    endcase
  endfunction

  function automatic logic op_legal(input logic [2:0] ctr);
    op_legal = (store_len(ctr) != 4'd0);
  endfunction

  function automatic logic op_misaligned(input logic [2:0] ctr, input logic [1:0] off);
    case (ctr)
      LH, LHU: op_misaligned = off[0];
      LW:      op_misaligned = (off != 2'b00);
      default: op_misaligned = 1'b0;
    endcase
  endfunction

  // Low address bits with the offending bits of a misaligned access cleared.
  function automatic logic [1:0] align_off(input logic [2:0] ctr, input logic [1:0] off);
    case (ctr)
      LH, LHU: align_off = {off[1], 1'b0};
      LW:      align_off = 2'b00;
      default: align_off = off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Request/response handshake bundle between the core memory stage and lsu_mem.
interface lsu_mem_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_ctr;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wd;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rd;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_ctr, req_addr, req_wd, resp_ready,
    input  req_ready, resp_valid, resp_rd, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_ctr, req_addr, req_wd, resp_ready,
    output req_ready, resp_valid, resp_rd, resp_err
  );
endinterface

// File: rtl/lsu_extract.sv
// Selects the addressed byte/halfword lane of a memory word and extends it.
module lsu_extract
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  ctr,
  output logic [31:0] rd
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by sign/zero extension per op.
  always_comb begin
    byte_s = word[{off, 3'b000} +: 8];
    half_s = off[1] ? word[31:16] : word[15:0];
    rd     = 32'd0;
    case (ctr)
      LB:      rd = {{24{byte_s[7]}}, byte_s};
      LBU:     rd = {24'd0, byte_s};
      LH:      rd = {{16{half_s[15]}}, half_s};
      LHU:     rd = {16'd0, half_s};
      LW:      rd = word;
      default: rd = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// Data-memory load/store unit: one transaction in flight, fixed access
// latency, byte-lane extraction and misaligned/illegal-op error responses.
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int LAT         = 1,
  parameter int CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_mem_if.slave    bus,
  output logic        pmem_re,
  output logic [31:0] pmem_raddr,
  input  logic [31:0] pmem_rdata,
  output logic        pmem_we,
  output logic [31:0] pmem_waddr,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_len
);

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_e            state_r, state_n;
  logic [3:0]        cnt_r, cnt_n;
  logic              we_r;
  logic [2:0]        ctr_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wd_r;
  logic              req_ready_r;
  logic              resp_valid_r;
  logic              resp_err_r;
  logic [31:0]       resp_rd_r;
  logic              accept_s;
  logic              bad_s;
  logic              access_s;
  logic [31:0]       load_rd_s;

  assign bad_s = !op_legal(bus.req_ctr) ||
                 ((CHECK_ALIGN != 0) && op_misaligned(bus.req_ctr, bus.req_addr[1:0]));

  assign access_s = (state_r == WAIT) && (cnt_r == 4'd0);

  // Next-state and counter logic.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          accept_s = 1'b1;
          if (bad_s) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_n = RESP;
        end else begin
          cnt_n = cnt_r - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_n = IDLE;
        end else begin
          state_n = RESP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, captured request and registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      we_r         <= 1'b0;
      ctr_r        <= LB;
      addr_r       <= '0;
      wd_r         <= 32'd0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rd_r    <= 32'd0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      req_ready_r <= (state_n == IDLE);
      if (accept_s) begin
        we_r   <= bus.req_we;
        ctr_r  <= bus.req_ctr;
        addr_r <= {bus.req_addr[ADDR_W-1:2], align_off(bus.req_ctr, bus.req_addr[1:0])};
        wd_r   <= bus.req_wd;
      end
      if (accept_s && bad_s) begin
        resp_valid_r <= 1'b1;
        resp_err_r   <= 1'b1;
        resp_rd_r    <= 32'd0;
      end else if (access_s) begin
        resp_valid_r <= 1'b1;
        resp_err_r   <= 1'b0;
        resp_rd_r    <= we_r ? 32'd0 : load_rd_s;
      end else if ((state_r == RESP) && bus.resp_ready) begin
        resp_valid_r <= 1'b0;
        resp_err_r   <= 1'b0;
        resp_rd_r    <= 32'd0;
      end
    end
  end

  lsu_extract u_extract (
    .word (pmem_rdata),
    .off  (addr_r[1:0]),
    .ctr  (ctr_r),
    .rd   (load_rd_s)
  );

  // Strobes are masked by rst_n so an access edge coinciding with reset is dropped.
  assign pmem_re    = access_s && !we_r && rst_n;
  assign pmem_raddr = {addr_r[31:2], 2'b00};
  assign pmem_we    = access_s && we_r && rst_n;
  assign pmem_waddr = addr_r[31:0];
  assign pmem_wdata = wd_r;
  assign pmem_len   = store_len(ctr_r);

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.resp_rd    = resp_rd_r;

endmodule

// File: tb/tb_lsu_mem.sv
// Bench for lsu_mem: dut0 (LAT=3, alignment checked), dut1 (LAT=4, aligned-down).
module tb_lsu_mem;
  import lsu_pkg::*;

  localparam int LAT0 = 3;
  localparam int LAT1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_if #(.ADDR_W(32)) bus0 ();
  lsu_mem_if #(.ADDR_W(32)) bus1 ();

  logic [1:0]  d_rst_n, d_valid, d_we, d_rready;
  logic [2:0]  d_ctr [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wd [2];
  logic [1:0]  o_rdy, o_val, o_err;
  logic [31:0] o_rd [2];

  logic [1:0]  pm_re, pm_we;
  logic [31:0] pm_raddr [2];
  logic [31:0] pm_rdata [2];
  logic [31:0] pm_waddr [2];
  logic [31:0] pm_wdata [2];
  logic [3:0]  pm_len [2];

  assign bus0.req_valid = d_valid[0];   assign bus1.req_valid = d_valid[1];
  assign bus0.req_we = d_we[0];         assign bus1.req_we = d_we[1];
  assign bus0.req_ctr = d_ctr[0];       assign bus1.req_ctr = d_ctr[1];
  assign bus0.req_addr = d_addr[0];     assign bus1.req_addr = d_addr[1];
  assign bus0.req_wd = d_wd[0];         assign bus1.req_wd = d_wd[1];
  assign bus0.resp_ready = d_rready[0]; assign bus1.resp_ready = d_rready[1];
  assign o_rdy[0] = bus0.req_ready;     assign o_rdy[1] = bus1.req_ready;
  assign o_val[0] = bus0.resp_valid;    assign o_val[1] = bus1.resp_valid;
  assign o_err[0] = bus0.resp_err;      assign o_err[1] = bus1.resp_err;
  assign o_rd[0] = bus0.resp_rd;        assign o_rd[1] = bus1.resp_rd;

  lsu_mem #(.ADDR_W(32), .LAT(LAT0), .CHECK_ALIGN(1)) dut0 (
    .clk(clk), .rst_n(d_rst_n[0]), .bus(bus0),
    .pmem_re(pm_re[0]), .pmem_raddr(pm_raddr[0]), .pmem_rdata(pm_rdata[0]),
    .pmem_we(pm_we[0]), .pmem_waddr(pm_waddr[0]), .pmem_wdata(pm_wdata[0]), .pmem_len(pm_len[0])
  );

  lsu_mem #(.ADDR_W(32), .LAT(LAT1), .CHECK_ALIGN(0)) dut1 (
    .clk(clk), .rst_n(d_rst_n[1]), .bus(bus1),
    .pmem_re(pm_re[1]), .pmem_raddr(pm_raddr[1]), .pmem_rdata(pm_rdata[1]),
    .pmem_we(pm_we[1]), .pmem_waddr(pm_waddr[1]), .pmem_wdata(pm_wdata[1]), .pmem_len(pm_len[1])
  );

  // Initial memory image; word 0x80000000 holds 0x8899AABB.
  function automatic logic [7:0] pat(input int i);
    logic [31:0] w;
    w = 32'h8899AABB;
    if (i < 4) return w[8*i +: 8];
    return 8'(i * 37 + 5);
  endfunction

  // Physical memory environment (byte array per DUT) with call counters.
  logic        fill;
  logic [7:0]  env_mem [0:1][0:1023];
  int          nrd [2];
  int          nwr [2];
  logic [31:0] lw_addr [2];
  logic [31:0] lw_data [2];
  logic [3:0]  lw_len [2];

  assign pm_rdata[0] = {env_mem[0][{pm_raddr[0][9:2], 2'd3}], env_mem[0][{pm_raddr[0][9:2], 2'd2}],
                        env_mem[0][{pm_raddr[0][9:2], 2'd1}], env_mem[0][{pm_raddr[0][9:2], 2'd0}]};
  assign pm_rdata[1] = {env_mem[1][{pm_raddr[1][9:2], 2'd3}], env_mem[1][{pm_raddr[1][9:2], 2'd2}],
                        env_mem[1][{pm_raddr[1][9:2], 2'd1}], env_mem[1][{pm_raddr[1][9:2], 2'd0}]};

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 1024; i++) begin
        env_mem[0][i] <= pat(i);
        env_mem[1][i] <= pat(i);
      end
      nrd[0] <= 0; nrd[1] <= 0; nwr[0] <= 0; nwr[1] <= 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (pm_re[k]) nrd[k] <= nrd[k] + 1;
        if (pm_we[k]) begin
          nwr[k]     <= nwr[k] + 1;
          lw_addr[k] <= pm_waddr[k];
          lw_data[k] <= pm_wdata[k];
          lw_len[k]  <= pm_len[k];
          for (int b = 0; b < 4; b++)
            if (b < int'(pm_len[k]))
              env_mem[k][pm_waddr[k][9:0] + 10'(b)] <= pm_wdata[k][8*b +: 8];
        end
      end
    end
  end

  // Transaction-level reference memory, written only by the model task.
  logic [7:0] ref_mem [0:1][0:1023];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input int k, input logic we, input logic [2:0] ctr, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err,
                       output int reads, output int writes, output logic [31:0] waddr, output int len);
    int size, off, ea;
    bit legal, mis, ca;
    longint v;
    ca    = (k == 0);
    legal = ctr inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    size  = (ctr[1:0] == 2'b00) ? 1 : (ctr[1:0] == 2'b01) ? 2 : 4;
    off   = int'(addr[9:0]);
    mis   = (off % size) != 0;
    ea    = off - (off % size);
    rd = 32'd0; err = 1'b0; reads = 0; writes = 0; waddr = 32'd0; len = 0;
    if (!legal || (ca && mis)) begin
      err = 1'b1;
    end else if (we) begin
      writes = 1;
      waddr  = {addr[31:10], 10'(ea)};
      len    = size;
      for (int i = 0; i < size; i++) ref_mem[k][ea + i] = wd[8*i +: 8];
    end else begin
      reads = 1;
      v = 0;
      for (int i = 0; i < size; i++) v += longint'(ref_mem[k][ea + i]) << (8 * i);
      if (ctr[2] == 1'b0 && size < 4 && v >= (64'sd1 << (8 * size - 1))) v -= (64'sd1 << (8 * size));
      rd = v[31:0];
    end
  endtask

  task automatic do_txn(input int k, input logic we, input logic [2:0] ctr, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold, output logic [31:0] rd_first,
                        output logic [31:0] rd_last, output logic err, output int lat,
                        output int bad_hs, output int dreads, output int dwrites);
    int w, n0r, n0w;
    w = 0;
    while (!o_rdy[k] && w < 50) begin tick(); w++; end
    d_we[k] = we; d_ctr[k] = ctr; d_addr[k] = addr; d_wd[k] = wd; d_valid[k] = 1'b1;
    n0r = nrd[k]; n0w = nwr[k];
    tick();
    // Scramble inputs after the accept edge; they must be ignored.
    d_valid[k] = 1'b0; d_we[k] = ~we; d_ctr[k] = 3'($urandom); d_addr[k] = $urandom; d_wd[k] = $urandom;
    lat = 0; bad_hs = 0;
    while (!o_val[k] && lat < 50) begin
      if (o_rdy[k]) bad_hs++;
      tick(); lat++;
    end
    if (!o_val[k]) lat = -1;
    rd_first = o_rd[k]; err = o_err[k];
    for (int h = 0; h < hold; h++) begin
      if (o_rdy[k] || !o_val[k]) bad_hs++;
      tick();
    end
    if (o_rdy[k] || !o_val[k]) bad_hs++;
    rd_last = o_rd[k];
    d_rready[k] = 1'b1; tick(); d_rready[k] = 1'b0;
    dreads = nrd[k] - n0r; dwrites = nwr[k] - n0w;
  endtask

  task automatic run_txn(input int k, input logic we, input logic [2:0] ctr, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold, input string tag,
                         output logic [31:0] act_rd, output logic act_err);
    logic [31:0] e_rd, e_waddr, rf, rl;
    logic e_err, err;
    int e_reads, e_writes, e_len, lat, bad_hs, dr, dw;
    model(k, we, ctr, addr, wd, e_rd, e_err, e_reads, e_writes, e_waddr, e_len);
    do_txn(k, we, ctr, addr, wd, hold, rf, rl, err, lat, bad_hs, dr, dw);
    chk({tag, "_rd"}, rf, e_rd);
    chk({tag, "_rd_held"}, rl, e_rd);
    chk({tag, "_err"}, 32'(err), 32'(e_err));
    chk({tag, "_lat"}, 32'(lat), 32'(e_err ? 0 : ((k == 0) ? LAT0 : LAT1)));
    chk({tag, "_handshake"}, 32'(bad_hs), 32'd0);
    chk({tag, "_reads"}, 32'(dr), 32'(e_reads));
    chk({tag, "_writes"}, 32'(dw), 32'(e_writes));
    if (e_writes == 1) begin
      chk({tag, "_waddr"}, lw_addr[k], e_waddr);
      chk({tag, "_wdata"}, lw_data[k], wd);
      chk({tag, "_wlen"}, 32'(lw_len[k]), 32'(e_len));
    end
    act_rd = rf; act_err = err;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  ctr;
    logic [31:0] addr;
    logic [31:0] wd;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  logic [2:0] legal_ops [5];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ard, e1, e2, tw;
    logic aerr, te;
    int tr, tws, tl, n0r, n0w, k;

    legal_ops = '{LB, LH, LW, LBU, LHU};
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 1024; i++) ref_mem[m][i] = pat(i);
    d_rst_n = 2'b00; fill = 1'b1; d_valid = 2'b00; d_we = 2'b00; d_rready = 2'b00;
    for (int m = 0; m < 2; m++) begin d_ctr[m] = 3'd0; d_addr[m] = 32'd0; d_wd[m] = 32'd0; end
    tick(); tick();
    fill = 1'b0; d_rst_n = 2'b11;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("reset%0d_ready", m), 32'(o_rdy[m]), 32'd1);
      chk($sformatf("reset%0d_valid", m), 32'(o_val[m]), 32'd0);
      chk($sformatf("reset%0d_rd", m), o_rd[m], 32'd0);
      chk($sformatf("reset%0d_err", m), 32'(o_err[m]), 32'd0);
    end

    // Directed vectors on dut0 (LAT=3, alignment checked).
    vecs.push_back('{1'b0, LB,     32'h80000001, 32'h0,        0, 32'hFFFFFFAA, 1'b0});
    vecs.push_back('{1'b0, LBU,    32'h80000001, 32'h0,        1, 32'h000000AA, 1'b0});
    vecs.push_back('{1'b0, LH,     32'h80000002, 32'h0,        0, 32'hFFFF8899, 1'b0});
    vecs.push_back('{1'b0, LHU,    32'h80000002, 32'h0,        2, 32'h00008899, 1'b0});
    vecs.push_back('{1'b0, LW,     32'h80000000, 32'h0,        0, 32'h8899AABB, 1'b0});
    vecs.push_back('{1'b1, LB,     32'h80000003, 32'h12345678, 0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, LW,     32'h80000000, 32'h0,        0, 32'h7899AABB, 1'b0});
    vecs.push_back('{1'b0, LW,     32'h80000002, 32'h0,        0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 3'b111, 32'h80000000, 32'h0,        1, 32'h0,        1'b1});
    vecs.push_back('{1'b0, LH,     32'h80000001, 32'h0,        0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, LHU,    32'h80000003, 32'h0,        0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 3'b011, 32'h80000000, 32'h0,        0, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 3'b110, 32'h80000008, 32'h11111111, 0, 32'h0,        1'b1});
    vecs.push_back('{1'b1, LW,     32'h80000005, 32'h22222222, 0, 32'h0,        1'b1});
    vecs.push_back('{1'b1, LW,     32'h80000004, 32'hDEADBEEF, 0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, LH,     32'h80000006, 32'h0,        0, 32'hFFFFDEAD, 1'b0});
    vecs.push_back('{1'b0, LBU,    32'h80000004, 32'h0,        0, 32'h000000EF, 1'b0});
    foreach (vecs[i]) begin
      run_txn(0, vecs[i].we, vecs[i].ctr, vecs[i].addr, vecs[i].wd, vecs[i].hold,
              $sformatf("vec%0d", i), ard, aerr);
      chk($sformatf("vec%0d_tbl_rd", i), ard, vecs[i].exp_rd);
      chk($sformatf("vec%0d_tbl_err", i), 32'(aerr), 32'(vecs[i].exp_err));
    end

    // Response held 5 cycles with a new request pending; it is accepted only after the handshake.
    model(0, 1'b0, LW, 32'h80000000, 32'h0, e1, te, tr, tws, tw, tl);
    model(0, 1'b0, LBU, 32'h80000001, 32'h0, e2, te, tr, tws, tw, tl);
    d_we[0] = 1'b0; d_ctr[0] = LW; d_addr[0] = 32'h80000000; d_valid[0] = 1'b1;
    tick();
    d_ctr[0] = LBU; d_addr[0] = 32'h80000001;
    repeat (LAT0) tick();
    for (int h = 0; h < 5; h++) begin
      chk($sformatf("hold%0d_valid", h), 32'(o_val[0]), 32'd1);
      chk($sformatf("hold%0d_rd", h), o_rd[0], e1);
      chk($sformatf("hold%0d_ready", h), 32'(o_rdy[0]), 32'd0);
      tick();
    end
    d_rready[0] = 1'b1; tick(); d_rready[0] = 1'b0;
    chk("post_hs_ready", 32'(o_rdy[0]), 32'd1);
    chk("post_hs_valid", 32'(o_val[0]), 32'd0);
    tick();
    d_valid[0] = 1'b0;
    chk("next_accepted", 32'(o_rdy[0]), 32'd0);
    repeat (LAT0) tick();
    chk("next_valid", 32'(o_val[0]), 32'd1);
    chk("next_rd", o_rd[0], e2);
    d_rready[0] = 1'b1; tick(); d_rready[0] = 1'b0;

    // dut1: misaligned accesses performed at the aligned-down address.
    run_txn(1, 1'b0, LW, 32'h80000012, 32'h0, 0, "al_lw", ard, aerr);
    run_txn(1, 1'b1, LH, 32'h80000013, 32'h1234BEEF, 0, "al_sh", ard, aerr);
    chk("al_sh_hand_addr", lw_addr[1], 32'h80000012);
    chk("al_sh_hand_len", 32'(lw_len[1]), 32'd2);
    run_txn(1, 1'b0, LHU, 32'h80000012, 32'h0, 0, "al_lhu", ard, aerr);
    chk("al_lhu_hand", ard, 32'h0000BEEF);

    // dut1: reset during the final WAIT cycle aborts the access.
    for (int s = 0; s < 2; s++) begin
      n0r = nrd[1]; n0w = nwr[1];
      d_we[1] = (s == 0); d_ctr[1] = LW; d_addr[1] = 32'h80000020; d_wd[1] = 32'hCAFEF00D;
      d_valid[1] = 1'b1;
      tick();
      d_valid[1] = 1'b0;
      repeat (LAT1 - 1) tick();
      chk($sformatf("rst%0d_pre_valid", s), 32'(o_val[1]), 32'd0);
      d_rst_n[1] = 1'b0;
      tick();
      chk($sformatf("rst%0d_ready", s), 32'(o_rdy[1]), 32'd1);
      chk($sformatf("rst%0d_valid", s), 32'(o_val[1]), 32'd0);
      chk($sformatf("rst%0d_rd", s), o_rd[1], 32'd0);
      chk($sformatf("rst%0d_err", s), 32'(o_err[1]), 32'd0);
      d_rst_n[1] = 1'b1;
      repeat (6) tick();
      chk($sformatf("rst%0d_no_write", s), 32'(nwr[1] - n0w), 32'd0);
      chk($sformatf("rst%0d_no_read", s), 32'(nrd[1] - n0r), 32'd0);
      chk($sformatf("rst%0d_idle_valid", s), 32'(o_val[1]), 32'd0);
    end
    run_txn(1, 1'b0, LW, 32'h80000020, 32'h0, 0, "rst_after_lw", ard, aerr);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 160; i++) begin
      logic [2:0] op;
      k = (i % 5 == 4) ? 1 : 0;
      if ($urandom_range(0, 3) == 0) op = 3'($urandom_range(0, 7));
      else op = legal_ops[$urandom_range(0, 4)];
      run_txn(k, 1'($urandom_range(0, 1)), op, 32'h80000000 + 32'($urandom_range(0, 47)),
              $urandom, $urandom_range(0, 2), $sformatf("rnd%0d", i), ard, aerr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
